ad_sampler: RTL and testbench



---
 rtl/ad_sampler_if.sv | 37 +++
 rtl/ad_sampler.sv | 154 +++++++++++++++
 tb/tb_ad_sampler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_sampler_if.sv
// ad_sampler_if: control inputs, ADC pad signals and parallel sample outputs of ad_sampler.
// master = sampler side, slave = consumer / pad side.
interface ad_sampler_if #(
    parameter int unsigned DATA_BITS = 12
);
    logic                 run;
    logic                 trig;
    logic                 peak_clr;
    logic                 ad_cs;
    logic [1:0]           ad_sdata_a;
    logic [1:0]           ad_sdata_b;
    logic [DATA_BITS-1:0] samp_a0;
    logic [DATA_BITS-1:0] samp_a1;
    logic [DATA_BITS-1:0] samp_b0;
    logic [DATA_BITS-1:0] samp_b1;
    logic                 sample_valid;
    logic                 frame_err;
    logic                 busy;
    logic [DATA_BITS-1:0] peak_a0;
    logic [DATA_BITS-1:0] peak_a1;
    logic [DATA_BITS-1:0] peak_b0;
    logic [DATA_BITS-1:0] peak_b1;

    modport master (
        input  run, trig, peak_clr, ad_sdata_a, ad_sdata_b,
        output ad_cs, samp_a0, samp_a1, samp_b0, samp_b1,
               sample_valid, frame_err, busy,
               peak_a0, peak_a1, peak_b0, peak_b1
    );

    modport slave (
        output run, trig, peak_clr, ad_sdata_a, ad_sdata_b,
        input  ad_cs, samp_a0, samp_a1, samp_b0, samp_b1,
               sample_valid, frame_err, busy,
               peak_a0, peak_a1, peak_b0, peak_b1
    );
endinterface

// File: rtl/ad_sampler.sv
// ad_sampler: frames dual-ADC conversions on ad_cs and deserialises four MSB-first lanes.
// Optional per-lane peak hold is enabled by defining AD_PEAK_HOLD_EN.
module ad_sampler #(
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned LEAD_BITS  = 2,
    parameter int unsigned TRAIL_BITS = 2,
    parameter int unsigned SAMPLE_DIV = 48
) (
    input  logic         clk,
    input  logic         reset,
    ad_sampler_if.master ad_if
);
    localparam int unsigned FRAME_LEN = LEAD_BITS + DATA_BITS + TRAIL_BITS;
    localparam int unsigned CNT_W     = $clog2(SAMPLE_DIV);
    localparam int unsigned STB_CNT   = LEAD_BITS + DATA_BITS + 1;
    localparam int unsigned LAST_BIT  = LEAD_BITS + DATA_BITS;
    localparam int unsigned LANES     = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GAP} state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            ad_cs_q, ad_cs_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;
    logic                            ferr_q, ferr_d;
    logic                            lerr_q, lerr_d;
    logic                            cap_lead, cap_data;
    logic [LANES-1:0]                lane_bits;
    logic [LANES-1:0][DATA_BITS-1:0] shift_q, shift_d;
    logic [LANES-1:0][DATA_BITS-1:0] samp_q, samp_d;
    logic [LANES-1:0][DATA_BITS-1:0] peak_q;

    // Lane order: 0=a0, 1=a1, 2=b0, 3=b1
    assign lane_bits = {ad_if.ad_sdata_b, ad_if.ad_sdata_a};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ad_if.run || ad_if.trig) state_d = ST_FRAME;
            end
            ST_FRAME: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ad_if.run ? ST_FRAME : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin leaves a flop.
    always_comb begin
        ad_cs_d  = (state_d != ST_FRAME);
        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_FRAME) && (cnt_d == CNT_W'(STB_CNT));
        cap_lead = (state_q == ST_FRAME) && (cnt_q >= CNT_W'(1)) &&
                   (cnt_q <= CNT_W'(LEAD_BITS));
        cap_data = (state_q == ST_FRAME) && (cnt_q > CNT_W'(LEAD_BITS)) &&
                   (cnt_q <= CNT_W'(LAST_BIT));
        lerr_d   = lerr_q;
        shift_d  = shift_q;
        if ((state_q == ST_FRAME) && (cnt_q == '0)) lerr_d = 1'b0;
        if (cap_lead) lerr_d = lerr_q | (|lane_bits);
        if (cap_data) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                shift_d[l] = {shift_q[l][DATA_BITS-2:0], lane_bits[l]};
            end
        end
        // The strobe edge is also the LSB capture edge, so take shift_d.
        samp_d = valid_d ? shift_d : samp_q;
        ferr_d = valid_d ? lerr_d : ferr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ad_cs_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            shift_q <= '0;
            samp_q  <= '0;
        end else begin
            ad_cs_q <= ad_cs_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            lerr_q  <= lerr_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
        end
    end

`ifdef AD_PEAK_HOLD_EN
    logic [LANES-1:0][DATA_BITS-1:0] peak_d;

    // Peaks follow the strobe by one cycle; a clear during the strobe reloads from the new sample.
    always_comb begin
        peak_d = peak_q;
        if (valid_q) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (ad_if.peak_clr || (samp_q[l] > peak_q[l])) peak_d[l] = samp_q[l];
            end
        end else if (ad_if.peak_clr) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end
`else
    logic peak_clr_unused;
    assign peak_clr_unused = ad_if.peak_clr;
    assign peak_q          = '0;
`endif

    assign ad_if.ad_cs        = ad_cs_q;
    assign ad_if.busy         = busy_q;
    assign ad_if.sample_valid = valid_q;
    assign ad_if.frame_err    = ferr_q;
    assign ad_if.samp_a0      = samp_q[0];
    assign ad_if.samp_a1      = samp_q[1];
    assign ad_if.samp_b0      = samp_q[2];
    assign ad_if.samp_b1      = samp_q[3];
    assign ad_if.peak_a0      = peak_q[0];
    assign ad_if.peak_a1      = peak_q[1];
    assign ad_if.peak_b0      = peak_q[2];
    assign ad_if.peak_b1      = peak_q[3];
endmodule

// File: tb/tb_ad_sampler.sv
// tb_ad_sampler: directed bench with a serial ADC model feeding a sample scoreboard.
module tb_ad_sampler;
    localparam int DATA = 12;
    localparam int LEAD = 2;
    localparam int DIV  = 48;

    typedef struct packed {
        logic [3:0][1:0]      lead;
        logic [3:0][DATA-1:0] data;
    } frame_t;

    typedef struct packed {
        logic [3:0][DATA-1:0] samp;
        logic                 err;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     lo_run = 0;
    int     hi_run = 0;
    int     pos = 0;
    int     c0;
    frame_t cur;
    frame_t frame_q[$];
    exp_t   exp_q[$];
    int     strobe_q[$];
    int     lo_q[$];
    int     hi_q[$];

    ad_sampler_if #(.DATA_BITS(DATA)) ad_if ();

    ad_sampler #(
        .DATA_BITS (DATA),
        .LEAD_BITS (LEAD),
        .TRAIL_BITS(2),
        .SAMPLE_DIV(DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ad_if(ad_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic frame_t mk(input logic [DATA-1:0] a0, input logic [DATA-1:0] a1,
                                  input logic [DATA-1:0] b0, input logic [DATA-1:0] b1,
                                  input logic [7:0] lead);
        frame_t f;
        f.data = {b1, b0, a1, a0};
        f.lead = lead;
        return f;
    endfunction

    // Serial bit i of lane l; trailing bits are driven high as don't-care traffic.
    function automatic logic fbit(input frame_t f, input int l, input int i);
        if (i < LEAD) return f.lead[l][LEAD-1-i];
        if (i < LEAD + DATA) return f.data[l][DATA-1-(i-LEAD)];
        return 1'b1;
    endfunction

    // ADC model: presents bit i during frame cycle cnt=i+1.
    initial begin
        logic [3:0] lb;
        exp_t       e;
        ad_if.ad_sdata_a = 2'b00;
        ad_if.ad_sdata_b = 2'b00;
        forever begin
            @(negedge clk);
            lb = 4'b0000;
            if (ad_if.ad_cs === 1'b0) begin
                if (pos == 0) begin
                    if (frame_q.size() > 0) cur = frame_q.pop_front();
                    else cur = '0;
                    e.samp = cur.data;
                    e.err  = |cur.lead;
                    exp_q.push_back(e);
                end else begin
                    for (int l = 0; l < 4; l++) lb[l] = fbit(cur, l, pos - 1);
                end
                pos++;
            end else begin
                pos = 0;
            end
            ad_if.ad_sdata_a = lb[1:0];
            ad_if.ad_sdata_b = lb[3:2];
        end
    end

    // Monitor: scoreboard on strobes plus chip-select run lengths.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ad_if.sample_valid === 1'b1) begin
                strobe_q.push_back(cyc);
                chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("samp_a0", 32'(ad_if.samp_a0), 32'(e.samp[0]));
                    chk("samp_a1", 32'(ad_if.samp_a1), 32'(e.samp[1]));
                    chk("samp_b0", 32'(ad_if.samp_b0), 32'(e.samp[2]));
                    chk("samp_b1", 32'(ad_if.samp_b1), 32'(e.samp[3]));
                    chk("frame_err", 32'(ad_if.frame_err), 32'(e.err));
                end
            end
            if (ad_if.ad_cs === 1'b0) begin
                if (hi_run > 0) hi_q.push_back(hi_run);
                hi_run = 0;
                lo_run++;
            end else begin
                if (lo_run > 0) lo_q.push_back(lo_run);
                lo_run = 0;
                if (ad_if.busy === 1'b1) hi_run++;
                else hi_run = 0;
            end
        end
    end

    task automatic goto_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic clear_q();
        strobe_q.delete();
        lo_q.delete();
        hi_q.delete();
    endtask

    task automatic shot(input frame_t f);
        frame_q.push_back(f);
        ad_if.trig = 1'b1;
        @(negedge clk);
        ad_if.trig = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        ad_if.run      = 1'b0;
        ad_if.trig     = 1'b0;
        ad_if.peak_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(ad_if.ad_cs), 32'd1);
        chk("rst_busy", 32'(ad_if.busy), 32'd0);
        chk("rst_valid", 32'(ad_if.sample_valid), 32'd0);
        chk("rst_samp_a0", 32'(ad_if.samp_a0), 32'd0);
        chk("rst_ferr", 32'(ad_if.frame_err), 32'd0);
        chk("rst_peak_a0", 32'(ad_if.peak_a0), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-shot conversion
        clear_q();
        frame_q.push_back(mk(12'hABC, 12'h123, 12'hFFF, 12'h000, 8'h00));
        ad_if.trig = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        ad_if.trig = 1'b0;
        chk("t1_cs_first_low", 32'(ad_if.ad_cs), 32'd0);
        goto_cyc(c0 + 47);
        chk("t1_busy_last", 32'(ad_if.busy), 32'd1);
        goto_cyc(c0 + 48);
        chk("t1_idle_busy", 32'(ad_if.busy), 32'd0);
        chk("t1_idle_cs", 32'(ad_if.ad_cs), 32'd1);
        goto_cyc(c0 + 60);
        chk("t1_strobes", 32'(strobe_q.size()), 32'd1);
        if (strobe_q.size() > 0) chk("t1_latency", 32'(strobe_q[0] - c0), 32'd15);
        chk("t1_cs_runs", 32'(lo_q.size()), 32'd1);
        if (lo_q.size() > 0) chk("t1_cs_low_len", 32'(lo_q[0]), 32'd16);

        // Free-run ramp, frame 2 carries a b1 leading-bit error
        clear_q();
        for (int k = 0; k < 5; k++) begin
            logic [DATA-1:0] r;
            r = DATA'(k * 32'h123 + 32'h010);
            frame_q.push_back(mk(r, r + 12'd1, r + 12'd2, r + 12'd3, (k == 1) ? 8'h40 : 8'h00));
        end
        ad_if.run = 1'b1;
        c0 = cyc + 1;
        goto_cyc(c0 + 4 * DIV + 20);
        ad_if.run = 1'b0;
        goto_cyc(c0 + 5 * DIV - 1);
        chk("t2_busy_end", 32'(ad_if.busy), 32'd1);
        goto_cyc(c0 + 5 * DIV);
        chk("t2_idle", 32'(ad_if.busy), 32'd0);
        goto_cyc(c0 + 5 * DIV + 10);
        chk("t2_strobes", 32'(strobe_q.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < strobe_q.size()) chk("t2_strobe_time", 32'(strobe_q[k] - c0), 32'(15 + DIV * k));
        chk("t2_gaps", 32'(hi_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < hi_q.size()) chk("t2_gap_len", 32'(hi_q[k]), 32'd32);
        chk("t2_exp_drained", 32'(exp_q.size()), 32'd0);

        // run dropped at cnt=5 of frame 3, trig during the final gap
        clear_q();
        frame_q.push_back(mk(12'h111, 12'h222, 12'h333, 12'h444, 8'h00));
        frame_q.push_back(mk(12'h555, 12'h666, 12'h777, 12'h888, 8'h00));
        frame_q.push_back(mk(12'h999, 12'hAAA, 12'hBBB, 12'hCCC, 8'h02));
        ad_if.run = 1'b1;
        c0 = cyc + 1;
        goto_cyc(c0 + 2 * DIV + 5);
        ad_if.run = 1'b0;
        goto_cyc(c0 + 2 * DIV + 30);
        ad_if.trig = 1'b1;
        @(negedge clk);
        ad_if.trig = 1'b0;
        goto_cyc(c0 + 3 * DIV);
        chk("t3_idle_busy", 32'(ad_if.busy), 32'd0);
        chk("t3_idle_cs", 32'(ad_if.ad_cs), 32'd1);
        goto_cyc(c0 + 3 * DIV + 40);
        chk("t3_trig_ignored", 32'(ad_if.busy), 32'd0);
        chk("t3_strobes", 32'(strobe_q.size()), 32'd3);
        if (strobe_q.size() > 2) chk("t3_strobe3_time", 32'(strobe_q[2] - c0), 32'(2 * DIV + 15));
        chk("t3_frames", 32'(lo_q.size()), 32'd3);
        chk("t3_exp_drained", 32'(exp_q.size()), 32'd0);

        // Reset at cnt=8 mid-frame
        clear_q();
        frame_q.push_back(mk(12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F, 8'h00));
        ad_if.trig = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        ad_if.trig = 1'b0;
        goto_cyc(c0 + 8);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_cs", 32'(ad_if.ad_cs), 32'd1);
        chk("t4_busy", 32'(ad_if.busy), 32'd0);
        chk("t4_valid", 32'(ad_if.sample_valid), 32'd0);
        chk("t4_samp_a0", 32'(ad_if.samp_a0), 32'd0);
        chk("t4_samp_b1", 32'(ad_if.samp_b1), 32'd0);
        chk("t4_ferr", 32'(ad_if.frame_err), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        clear_q();
        repeat (60) @(negedge clk);
        chk("t4_no_strobe", 32'(strobe_q.size()), 32'd0);
        chk("t4_still_idle", 32'(ad_if.busy), 32'd0);

`ifdef AD_PEAK_HOLD_EN
        shot(mk(12'h100, 12'h000, 12'h000, 12'h000, 8'h00));
        shot(mk(12'h800, 12'h000, 12'h000, 12'h000, 8'h00));
        shot(mk(12'h400, 12'h000, 12'h000, 12'h000, 8'h00));
        chk("pk_max_a0", 32'(ad_if.peak_a0), 32'h800);
        frame_q.push_back(mk(12'h050, 12'h000, 12'h000, 12'h000, 8'h00));
        ad_if.trig = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        ad_if.trig = 1'b0;
        goto_cyc(c0 + 15);
        chk("pk_strobe_cycle", 32'(ad_if.sample_valid), 32'd1);
        ad_if.peak_clr = 1'b1;
        @(negedge clk);
        ad_if.peak_clr = 1'b0;
        chk("pk_clr_with_strobe", 32'(ad_if.peak_a0), 32'h050);
        repeat (40) @(negedge clk);
        ad_if.peak_clr = 1'b1;
        @(negedge clk);
        ad_if.peak_clr = 1'b0;
        chk("pk_clr_alone", 32'(ad_if.peak_a0), 32'd0);
`else
        shot(mk(12'h800, 12'h7FF, 12'h0AA, 12'h001, 8'h00));
        chk("pk_tied_a0", 32'(ad_if.peak_a0), 32'd0);
        chk("pk_tied_a1", 32'(ad_if.peak_a1), 32'd0);
`endif
        chk("end_exp_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
